// File: rtl/sdram_pkg.sv
// Shared constants and FSM encoding for the SDRAM FIFO scheduler.
// SDRAM word address = bank | row | col.
package sdram_pkg;

  localparam int unsigned BANK_W       = 2;
  localparam int unsigned ROW_W        = 13;
  localparam int unsigned COL_W        = 9;
  localparam int unsigned SDRAM_ADDR_W = BANK_W + ROW_W + COL_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_BURST,
    ST_RD_REQ,
    ST_RD_BURST
  } state_t;

endpackage

// File: rtl/sdram_fifo_ctrl_if.sv
// Request/acknowledge handshake between the FIFO scheduler (master)
// and the SDRAM controller (slave).
interface sdram_fifo_ctrl_if
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = SDRAM_ADDR_W
);

  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;

  modport master (
    output sdram_wr_req, sdram_rd_req, sdram_addr,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sdram_addr,
    output sdram_wr_ack, sdram_rd_ack
  );

endinterface

// File: rtl/sdram_load_sync.sv
// Two-flop synchroniser plus rising-edge detect for an asynchronous load level.
// The pulse is registered, so it appears three clocks after the level rises.
module sdram_load_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], level};
      pulse <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// Upstream scheduler for the SDRAM controller: issues write/read burst requests from
// FIFO fill levels and owns the wrapping write/read address pointers.
module sdram_fifo_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W      = SDRAM_ADDR_W,
  parameter int unsigned USED_W      = 11,
  parameter int unsigned RFIFO_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic [9:0]        wr_burst_len,
  input  logic [9:0]        rd_burst_len,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              read_valid,
  input  logic [USED_W-1:0] wfifo_used,
  input  logic [USED_W-1:0] rfifo_used,
  sdram_fifo_ctrl_if.master bus,
  output logic              wfifo_rd_en,
  output logic              rfifo_wr_en,
  output logic              wfifo_clr,
  output logic              rfifo_clr
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [9:0]        wr_len, rd_len;
  logic              wr_pend, rd_pend;
  logic              wr_ack_d, rd_ack_d;
  logic              wr_req_q, rd_req_q;
  logic              wr_ack_fall, rd_ack_fall;
  logic              wr_ok, rd_ok;
  logic [USED_W:0]   rd_sum;

  // Advance by one burst; wrap early so the following burst cannot cross hi.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] addr,
                                                 input logic [ADDR_W-1:0] lo,
                                                 input logic [ADDR_W-1:0] hi,
                                                 input logic [9:0]        len);
    logic [ADDR_W:0] nxt;
    nxt = {1'b0, addr} + (ADDR_W+1)'(len);
    if (nxt + (ADDR_W+1)'(len) > {1'b0, hi}) return lo;
    return nxt[ADDR_W-1:0];
  endfunction

  sdram_load_sync u_wr_sync (.clk(clk), .rst_n(rst_n), .level(wr_load), .pulse(wfifo_clr));
  sdram_load_sync u_rd_sync (.clk(clk), .rst_n(rst_n), .level(rd_load), .pulse(rfifo_clr));

  assign wr_ack_fall = wr_ack_d & ~bus.sdram_wr_ack;
  assign rd_ack_fall = rd_ack_d & ~bus.sdram_rd_ack;
  assign wr_ok       = (USED_W+1)'(wfifo_used) >= (USED_W+1)'(wr_burst_len);
  assign rd_sum      = (USED_W+1)'(rfifo_used) + (USED_W+1)'(rd_burst_len);
  assign rd_ok       = read_valid && (rd_sum <= (USED_W+1)'(RFIFO_DEPTH));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (sdram_init_done) begin
          if (wr_ok)      state_nxt = ST_WR_REQ;
          else if (rd_ok) state_nxt = ST_RD_REQ;
        end
      end
      ST_WR_REQ:   if (bus.sdram_wr_ack) state_nxt = ST_WR_BURST;
      ST_WR_BURST: if (wr_ack_fall)      state_nxt = ST_IDLE;
      ST_RD_REQ:   if (bus.sdram_rd_ack) state_nxt = ST_RD_BURST;
      ST_RD_BURST: if (rd_ack_fall)      state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      wr_ack_d <= 1'b0;
      rd_ack_d <= 1'b0;
      wr_len   <= '0;
      rd_len   <= '0;
    end else begin
      state    <= state_nxt;
      wr_req_q <= (state_nxt == ST_WR_REQ);
      rd_req_q <= (state_nxt == ST_RD_REQ);
      wr_ack_d <= bus.sdram_wr_ack;
      rd_ack_d <= bus.sdram_rd_ack;
      if (state == ST_IDLE && state_nxt == ST_WR_REQ) wr_len <= wr_burst_len;
      if (state == ST_IDLE && state_nxt == ST_RD_REQ) rd_len <= rd_burst_len;
    end
  end

  // Loads only take effect in IDLE; an edge seen elsewhere is parked in *_pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      if (state == ST_WR_BURST && wr_ack_fall)
        wr_addr <= next_ptr(wr_addr, wr_min_addr, wr_max_addr, wr_len);
      else if (state == ST_IDLE && (wr_pend || wfifo_clr))
        wr_addr <= wr_min_addr;

      if (state == ST_RD_BURST && rd_ack_fall)
        rd_addr <= next_ptr(rd_addr, rd_min_addr, rd_max_addr, rd_len);
      else if (state == ST_IDLE && (rd_pend || rfifo_clr))
        rd_addr <= rd_min_addr;

      if (state == ST_IDLE) wr_pend <= 1'b0;
      else if (wfifo_clr)   wr_pend <= 1'b1;

      if (state == ST_IDLE) rd_pend <= 1'b0;
      else if (rfifo_clr)   rd_pend <= 1'b1;
    end
  end

  assign bus.sdram_wr_req = wr_req_q;
  assign bus.sdram_rd_req = rd_req_q;
  assign bus.sdram_addr   = (state == ST_WR_REQ || state == ST_WR_BURST) ? wr_addr : rd_addr;
  assign wfifo_rd_en      = bus.sdram_wr_ack;
  assign rfifo_wr_en      = bus.sdram_rd_ack;

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Self-checking bench for sdram_fifo_ctrl: directed scenarios plus randomized
// FIFO levels and burst lengths against a behavioural pointer/arbitration model.
module tb_sdram_fifo_ctrl;

  localparam int unsigned AW    = 24;
  localparam int unsigned UW    = 11;
  localparam int unsigned DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic [AW-1:0] wr_min = '0, wr_max = '0, rd_min = '0, rd_max = '0;
  logic [9:0]    wr_len = 10'd8, rd_len = 10'd8;
  logic          wr_load = 1'b0, rd_load = 1'b0, read_valid = 1'b0;
  logic [UW-1:0] wfifo_used = '0, rfifo_used = '0;
  logic          wr_ack = 1'b0, rd_ack = 1'b0;
  logic          wfifo_rd_en, rfifo_wr_en, wfifo_clr, rfifo_clr;

  int checks = 0;
  int errors = 0;
  int unsigned wr_ptr_m = 0, rd_ptr_m = 0;

  sdram_fifo_ctrl_if #(.ADDR_W(AW)) bus ();

  assign bus.sdram_wr_ack = wr_ack;
  assign bus.sdram_rd_ack = rd_ack;

  sdram_fifo_ctrl #(.ADDR_W(AW), .USED_W(UW), .RFIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done),
    .wr_min_addr(wr_min), .wr_max_addr(wr_max), .rd_min_addr(rd_min), .rd_max_addr(rd_max),
    .wr_burst_len(wr_len), .rd_burst_len(rd_len), .wr_load(wr_load), .rd_load(rd_load),
    .read_valid(read_valid), .wfifo_used(wfifo_used), .rfifo_used(rfifo_used),
    .bus(bus), .wfifo_rd_en(wfifo_rd_en), .rfifo_wr_en(rfifo_wr_en),
    .wfifo_clr(wfifo_clr), .rfifo_clr(rfifo_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Window rule: next start = cur+len unless a further burst of len would pass hi.
  function automatic int unsigned advance(input int unsigned p, input int unsigned len,
                                          input int unsigned lo, input int unsigned hi);
    if (p + 2 * len > hi) return lo;
    return p + len;
  endfunction

  task automatic wait_req(input bit is_wr, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_wr ? bus.sdram_wr_req : bus.sdram_rd_req) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(is_wr ? "wr_req_seen" : "rd_req_seen", 32'(seen), 32'd1);
  endtask

  task automatic serve(input bit is_wr, input int unsigned len, input int unsigned exp_addr);
    bit seen;
    wait_req(is_wr, seen);
    if (!seen) return;
    check_eq(is_wr ? "wr_start_addr" : "rd_start_addr", 32'(bus.sdram_addr), exp_addr);
    check_eq("req_exclusive", 32'(bus.sdram_wr_req & bus.sdram_rd_req), 32'd0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    for (int unsigned k = 0; k < len; k++) begin
      if (is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        check_eq("req_drop_on_ack", 32'(is_wr ? bus.sdram_wr_req : bus.sdram_rd_req), 32'd0);
        check_eq("fifo_strobe", 32'(is_wr ? wfifo_rd_en : rfifo_wr_en), 32'd1);
      end
    end
    wr_ack = 1'b0;
    rd_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int unsigned old_addr;
    bit exp_wr, exp_rd;

    repeat (3) @(negedge clk);
    check_eq("rst_reqs", {30'd0, bus.sdram_wr_req, bus.sdram_rd_req}, 32'd0);
    check_eq("rst_addr", 32'(bus.sdram_addr), 32'd0);
    check_eq("rst_clr", {30'd0, wfifo_clr, rfifo_clr}, 32'd0);
    rst_n = 1'b1;

    // Scenario 1/2: eight bursts of 8 in [0,64), then one more after the wrap
    wr_min = 24'd0; wr_max = 24'd64; wr_len = 10'd8; wfifo_used = 11'd8;
    repeat (3) @(negedge clk);
    check_eq("no_req_before_init", {30'd0, bus.sdram_wr_req, bus.sdram_rd_req}, 32'd0);
    init_done = 1'b1;
    @(negedge clk);
    check_eq("wr_req_after_init", 32'(bus.sdram_wr_req), 32'd1);
    for (int i = 0; i < 9; i++) begin
      serve(1'b1, 8, wr_ptr_m);
      wr_ptr_m = advance(wr_ptr_m, 8, 0, 64);
      if (i == 8) wfifo_used = '0;
    end
    check_eq("wr_wrap_model", wr_ptr_m, 32'd8);

    // Scenario 4: read space boundary, after loading rd pointer to its window start
    rd_min = 24'd256; rd_max = 24'd512; rd_len = 10'd8; rfifo_used = 11'd1020; read_valid = 1'b1;
    rd_load = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("rfifo_clr_timing", 32'(rfifo_clr), (k == 3) ? 32'd1 : 32'd0);
    end
    rd_load = 1'b0;
    rd_ptr_m = 256;
    check_eq("no_rd_req_full", 32'(bus.sdram_rd_req), 32'd0);
    rfifo_used = 11'd1016;
    serve(1'b0, 8, rd_ptr_m);
    rd_ptr_m = advance(rd_ptr_m, 8, 256, 512);
    rfifo_used = 11'd1020;

    // Scenario 3: write and read eligible together, write first
    repeat (3) @(negedge clk);
    wfifo_used = 11'd8; rfifo_used = 11'd0;
    serve(1'b1, 8, wr_ptr_m);
    wr_ptr_m = advance(wr_ptr_m, 8, 0, 64);
    wfifo_used = '0;
    serve(1'b0, 8, rd_ptr_m);
    rd_ptr_m = advance(rd_ptr_m, 8, 256, 512);
    rfifo_used = 11'd1020;

    // Scenario 5: wr_load edge during a write burst
    repeat (3) @(negedge clk);
    wr_min = 24'd32; wr_max = 24'd128; wr_len = 10'd16; wfifo_used = 11'd16;
    old_addr = wr_ptr_m;
    wait_req(1'b1, seen);
    check_eq("wr5_start_addr", 32'(bus.sdram_addr), old_addr);
    wr_ack = 1'b1;
    wr_load = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 5) check_eq("wfifo_clr_timing", 32'(wfifo_clr), (k == 3) ? 32'd1 : 32'd0);
      if (k == 6) check_eq("wr_addr_held_mid_burst", 32'(bus.sdram_addr), old_addr);
    end
    wr_ack = 1'b0; wfifo_used = '0; wr_load = 1'b0;
    wr_ptr_m = 32;
    repeat (3) @(negedge clk);
    wfifo_used = 11'd16;
    serve(1'b1, 16, wr_ptr_m);
    wr_ptr_m = advance(wr_ptr_m, 16, 32, 128);
    wfifo_used = '0;

    // Scenario 6: reset in the middle of a read burst
    repeat (3) @(negedge clk);
    rfifo_used = 11'd0;
    wait_req(1'b0, seen);
    rd_ack = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; rd_ack = 1'b0; read_valid = 1'b0;
    #1;
    check_eq("midrst_reqs", {30'd0, bus.sdram_wr_req, bus.sdram_rd_req}, 32'd0);
    check_eq("midrst_addr", 32'(bus.sdram_addr), 32'd0);
    check_eq("midrst_strobes", {28'd0, wfifo_rd_en, rfifo_wr_en, wfifo_clr, rfifo_clr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_ptr_m = 0; rd_ptr_m = 0;
    wr_min = 24'd0; wr_max = 24'd200; wr_len = 10'd8; wfifo_used = 11'd8;
    serve(1'b1, 8, wr_ptr_m);
    wr_ptr_m = advance(wr_ptr_m, 8, 0, 200);
    wfifo_used = '0; read_valid = 1'b1;
    serve(1'b0, 8, rd_ptr_m);
    rd_ptr_m = advance(rd_ptr_m, 8, 256, 512);
    rfifo_used = 11'd1023; rd_len = 10'd8;
    repeat (3) @(negedge clk);

    // Randomized levels and burst lengths against the arbitration/pointer model
    for (int it = 0; it < 40; it++) begin
      wr_len     = 10'($urandom_range(1, 16));
      rd_len     = 10'($urandom_range(1, 16));
      wfifo_used = 11'($urandom_range(0, 24));
      rfifo_used = 11'($urandom_range(1000, 1023));
      read_valid = 1'($urandom_range(0, 1));
      exp_wr = (int'(wfifo_used) >= int'(wr_len));
      exp_rd = !exp_wr && read_valid && (int'(rfifo_used) + int'(rd_len) <= int'(DEPTH));
      if (exp_wr) begin
        serve(1'b1, int'(wr_len), wr_ptr_m);
        wr_ptr_m = advance(wr_ptr_m, int'(wr_len), 0, 200);
      end else if (exp_rd) begin
        serve(1'b0, int'(rd_len), rd_ptr_m);
        rd_ptr_m = advance(rd_ptr_m, int'(rd_len), 256, 512);
      end else begin
        repeat (4) @(negedge clk);
        check_eq("rand_no_req", {30'd0, bus.sdram_wr_req, bus.sdram_rd_req}, 32'd0);
      end
      wfifo_used = '0;
      read_valid = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
